mem_responder: RTL and testbench

// - Responder end of the memory request interface driven by fetch (and later by the data-memory stage).
// - Holds a word array and accepts one request per handshake: read or write, 16-bit address, 16-bit data.
// - Returns data_out / err / wr_success a configurable LATENCY after acceptance.
// - Flags misaligned and out-of-range addresses as errors.
// - Sits below fetch; with LATENCY=1 it presents synchronous-RAM timing with back-to-back issue.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding, captured request record
// and latency counter width.
package mem_pkg;

  localparam int LAT_CNT_W  = 4;
  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  wr;
    logic [REQ_DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, combinational read of the same index.
// INIT_FILE is kept as a parameter for interface compatibility; contents are never reset.
module mem_array #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 1024,
   parameter int IDX_W     = $clog2(DEPTH),
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Synchronous write of the addressed word when the write enable is high.
   always_ff @(posedge clk) begin
      if (we) mem_q[idx] <= wdata;
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memory request interface: accepts one read/write per handshake
// and returns data/err/wr_success a fixed LATENCY of cycles after acceptance.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = REQ_ADDR_W,
  parameter int DATA_W    = REQ_DATA_W,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              err,
  output logic              wr_success
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  mem_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t             req_q, req_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 err_q, err_d;
  logic                 wr_success_q, wr_success_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;

  mem_req_t             live_req, rsp_req;
  logic                 accept, respond, rsp_err, mem_we;
  logic [ADDR_W-1:0]    word_idx;
  logic [DATA_W-1:0]    rd_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = enable && req_ready;
  assign live_req  = '{addr: addr, wr: wr, data: data_in};

  // With LATENCY=1 the response is formed from the live inputs at the accept edge;
  // otherwise from the request captured when it was accepted.
  assign rsp_req  = (state_q == IDLE) ? live_req : req_q;
  assign respond  = (state_q == IDLE) ? (accept && (LATENCY == 1))
                                      : (cnt_q == LAT_CNT_W'(1));
  assign word_idx = {1'b0, rsp_req.addr[ADDR_W-1:1]};
  assign rsp_err  = rsp_req.addr[0] || (word_idx >= ADDR_W'(MEM_WORDS));
  assign mem_we   = respond && rsp_req.wr && !rsp_err;

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (MEM_WORDS),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (rsp_req.addr[IDX_W:1]),
    .wdata (rsp_req.data),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rsp_valid_d  = 1'b0;
    err_d        = 1'b0;
    wr_success_d = 1'b0;
    data_out_d   = data_out_q;

    case (state_q)
      IDLE: begin
        if (accept && (LATENCY > 1)) begin
          state_d = BUSY;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          req_d   = live_req;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q == LAT_CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Writes leave data_out untouched; errors force it to zero.
    if (respond) begin
      rsp_valid_d = 1'b1;
      if (rsp_err) begin
        err_d      = 1'b1;
        data_out_d = '0;
      end else if (rsp_req.wr) begin
        wr_success_d = 1'b1;
      end else begin
        data_out_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      rsp_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      wr_success_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rsp_valid_q  <= rsp_valid_d;
      err_q        <= err_d;
      wr_success_q <= wr_success_d;
      data_out_q   <= data_out_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign err        = err_q;
  assign wr_success = wr_success_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances with LATENCY 1..4, directed
// requests push expected responses, a negedge monitor pops and compares them.
module tb_mem_responder;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]       rstS, enS, wrS, rdyS, vldS, errS, okS;
   logic [N-1:0][15:0] addrS, dinS, doutS;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         mem_responder #(
            .ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(g + 1), .INIT_FILE("")
         ) u_dut (
            .clk(clk), .rst(rstS[g]), .addr(addrS[g]), .enable(enS[g]), .data_in(dinS[g]),
            .wr(wrS[g]), .req_ready(rdyS[g]), .rsp_valid(vldS[g]), .data_out(doutS[g]),
            .err(errS[g]), .wr_success(okS[g])
         );
      end
   endgenerate

   typedef struct {
      int          due;
      logic [15:0] data;
      logic        err;
      logic        ok;
      int          tag;
   } exp_t;

   exp_t expQ [N][$];
   int   cycleCnt   = 0;
   int   compared   = 0;
   int   mismatched = 0;
   int   tagNext    = 0;

   // Cycle index of the most recent rising edge, used to place expected responses.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor: every response must match the oldest expectation due this cycle;
   // non-response cycles must keep err and wr_success low.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         logic expV;
         exp_t e;
         if (expQ[k].size() > 0 && expQ[k][0].due < cycleCnt) begin
            e = expQ[k].pop_front();
            compared++; mismatched++;
            $display("[TB] FAIL late dut%0d tag%0d: no response by cycle %0d", k, e.tag, e.due);
         end
         expV = (expQ[k].size() > 0) && (expQ[k][0].due == cycleCnt);
         if (vldS[k] || expV) begin
            compared++;
            if (!expV) begin
               mismatched++;
               $display("[TB] FAIL unexpected dut%0d: rsp_valid=1 data=%h err=%b ok=%b cycle %0d",
                        k, doutS[k], errS[k], okS[k], cycleCnt);
            end else begin
               e = expQ[k].pop_front();
               if (!vldS[k]) begin
                  mismatched++;
                  $display("[TB] FAIL missing dut%0d tag%0d: rsp_valid=0, want 1 at cycle %0d",
                           k, e.tag, cycleCnt);
               end else if (doutS[k] !== e.data || errS[k] !== e.err || okS[k] !== e.ok) begin
                  mismatched++;
                  $display("[TB] FAIL rsp dut%0d tag%0d: got data=%h err=%b ok=%b want data=%h err=%b ok=%b",
                           k, e.tag, doutS[k], errS[k], okS[k], e.data, e.err, e.ok);
               end
            end
         end else begin
            compared++;
            if (errS[k] !== 1'b0 || okS[k] !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL idleflags dut%0d: err=%b ok=%b want 0 0", k, errS[k], okS[k]);
            end
         end
      end
   end

   // Direct comparison of a sampled value against its required value.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic checkResetState(input int k);
      checkOutput($sformatf("rst_rdy%0d", k), 16'(rdyS[k]), 16'h1);
      checkOutput($sformatf("rst_vld%0d", k), 16'(vldS[k]), 16'h0);
      checkOutput($sformatf("rst_dout%0d", k), doutS[k], 16'h0);
      checkOutput($sformatf("rst_err%0d", k), 16'(errS[k]), 16'h0);
      checkOutput($sformatf("rst_ok%0d", k), 16'(okS[k]), 16'h0);
   endtask

   // Drives one request in the next cycle where req_ready is high; optionally
   // records the response expected LATENCY (=k+1) edges later.
   task automatic applyStimulus(input int k, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic push,
                                input logic [15:0] eData, input logic eErr, input logic eOk);
      int waited = 0;
      @(negedge clk);
      while (!rdyS[k] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!rdyS[k]) begin
         compared++; mismatched++;
         $display("[TB] FAIL ready_timeout dut%0d: req_ready=0, want 1", k);
      end
      enS[k] = 1'b1; wrS[k] = w; addrS[k] = a; dinS[k] = d;
      if (push) begin
         expQ[k].push_back('{due: cycleCnt + k + 1, data: eData, err: eErr, ok: eOk, tag: tagNext});
         tagNext++;
      end
   endtask

   task automatic idle(input int k);
      @(negedge clk);
      enS[k] = 1'b0; wrS[k] = 1'b0;
   endtask

   // Next cycle must be busy; drives a new read request that has to be ignored.
   task automatic busyDrive(input int k, input logic [15:0] a);
      @(negedge clk);
      checkOutput($sformatf("busy_rdy%0d", k), 16'(rdyS[k]), 16'h0);
      enS[k] = 1'b1; wrS[k] = 1'b0; addrS[k] = a;
   endtask

   task automatic busyIdleCheck(input int k);
      @(negedge clk);
      enS[k] = 1'b0; wrS[k] = 1'b0;
      checkOutput($sformatf("busy_rdy%0d", k), 16'(rdyS[k]), 16'h0);
   endtask

   task automatic drain(input int k);
      int n = 0;
      while (expQ[k].size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (expQ[k].size() > 0) begin
         compared++; mismatched++;
         $display("[TB] FAIL drain dut%0d: %0d responses outstanding, want 0", k, expQ[k].size());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstS = '0; enS = '0; wrS = '0; addrS = '0; dinS = '0;
      #1 rstS = '1;
      #2;
      for (int k = 0; k < N; k++) checkResetState(k);
      @(negedge clk);
      rstS = '0;

      // LATENCY=1: preload words 0..3, then back-to-back reads on consecutive cycles.
      applyStimulus(0, 1'b1, 16'h0000, 16'h1111, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 16'h0002, 16'h2222, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 16'h0004, 16'h3333, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 16'h0006, 16'h4444, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 16'h0004, 16'h0000, 1'b1, 16'h3333, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 16'h0006, 16'h0000, 1'b1, 16'h4444, 1'b0, 1'b0);
      idle(0);
      drain(0);

      // Mid-cycle reset clears outputs without a clock edge.
      @(negedge clk);
      checkOutput("hold_dout0", doutS[0], 16'h4444);
      #2 rstS[0] = 1'b1;
      #1 checkResetState(0);
      #1 rstS[0] = 1'b0;

      // LATENCY=3: write stalls for two cycles, then read-back, errors, range check.
      applyStimulus(2, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b1);
      busyIdleCheck(2);
      busyIdleCheck(2);
      applyStimulus(2, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      applyStimulus(2, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(2, 1'b1, 16'h0800, 16'hDEAD, 1'b1, 16'h0000, 1'b1, 1'b0);
      applyStimulus(2, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0);
      idle(2);
      drain(2);

      // LATENCY=2: request changes while busy are ignored; next accept in response cycle.
      applyStimulus(1, 1'b1, 16'h0020, 16'h7777, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 16'h0022, 16'h8888, 1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h7777, 1'b0, 1'b0);
      busyDrive(1, 16'h0003);
      applyStimulus(1, 1'b0, 16'h0022, 16'h0000, 1'b1, 16'h8888, 1'b0, 1'b0);
      idle(1);
      drain(1);

      // LATENCY=4: reset two cycles into a write aborts it and keeps the old word.
      applyStimulus(3, 1'b1, 16'h000A, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b1);
      idle(3);
      drain(3);
      applyStimulus(3, 1'b1, 16'h000A, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
      idle(3);
      @(negedge clk);
      rstS[3] = 1'b1;
      #1 checkResetState(3);
      @(negedge clk);
      rstS[3] = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(3, 1'b0, 16'h000A, 16'h0000, 1'b1, 16'h5555, 1'b0, 1'b0);
      idle(3);
      drain(3);

      repeat (4) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
